musb_mem_arbiter: RTL
=====================

# musb_mem_arbiter

Shares a single memory bus port between the instruction-fetch and data-access paths of the MUSB core. Grants one single-beat transaction at a time, data before instruction, and holds bus signals stable until the slave responds or a watchdog expires. Returns the read data and a one-cycle ready/error pulse to the owning master. Generates the `imem_request_stall` / `dmem_request_stall` inputs consumed by the hazard/pipeline control unit.

## Interface
- `ADDR_WIDTH`, 32: address width for both masters and the bus.
- `DATA_WIDTH`, 32: data width; byte enables are `DATA_WIDTH/8` bits wide.
- `TIMEOUT`, 255: maximum cycles a granted transaction waits for a response before being terminated with error (1..2^16-1).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` in 1: instruction read request, held until `imem_ready`.
- `imem_addr` in ADDR_WIDTH: fetch address.
- `imem_data` out DATA_WIDTH: fetched word; valid while `imem_ready`=1.
- `imem_ready` out 1: one-cycle completion pulse.
- `imem_error` out 1: pulses with `imem_ready` on bus error or timeout.
- `imem_request_stall` out 1: `imem_req & ~imem_ready`.
- `dmem_req` in 1: data request, held until `dmem_ready`.
- `dmem_we` in 1: 1 = write, 0 = read.
- `dmem_addr` in ADDR_WIDTH; `dmem_wdata` in DATA_WIDTH; `dmem_be` in DATA_WIDTH/8.
- `dmem_rdata` out DATA_WIDTH: read word; valid while `dmem_ready`=1.
- `dmem_ready` out 1; `dmem_error` out 1: as for the instruction port.
- `dmem_request_stall` out 1: `dmem_req & ~dmem_ready`.
- `bus_valid` out 1; `bus_we` out 1; `bus_addr` out ADDR_WIDTH; `bus_wdata` out DATA_WIDTH; `bus_be` out DATA_WIDTH/8: registered master-side bus.
- `bus_rdata` in DATA_WIDTH; `bus_ready` in 1; `bus_error` in 1: slave response, sampled only while `bus_valid`=1.

## Operation
- FSM states: IDLE, IMEM, DMEM, RESP.
- IDLE:
  - if `dmem_req` → DMEM; latch `dmem_addr/wdata/be/we` into the bus registers and set `bus_valid`.
  - else if `imem_req` → IMEM; latch `imem_addr`, `bus_we`=0, `bus_be`=all ones, `bus_wdata`=0.
  - Fixed priority: data always wins when both requests are present.
- IMEM/DMEM:
  - Bus outputs are held stable.
  - The watchdog counter is cleared on grant and increments each cycle with no response.
  - Completion occurs on `bus_ready` or `bus_error`, or when the counter reaches TIMEOUT-1 with no response.
  - On completion, go to RESP and clear `bus_valid`.
  - Capture `bus_rdata` into the owner's data register; capture 0 instead if completion is by error or timeout.
  - Set the owner's error bit on `bus_error` or timeout; `bus_error` wins when it arrives together with `bus_ready`.
- RESP:
  - Owner's `*_ready` (and `*_error` if set) is high for exactly this cycle.
  - All requests are ignored this cycle, because the master's `req` still refers to the completed access.
  - Next state is IDLE.
- Data outputs hold their last captured value until the next completion on that port.
- Write transactions also capture `bus_rdata`; that value is don't-care for masters.
- A request dropped mid-transaction (pipeline flush) does not abort the bus access; it completes and still pulses ready.
- Reset: state IDLE, counter 0. All outputs 0: `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, both ready/error/data outputs, and both stall outputs (stalls follow `req` after reset).

## Timing
- Zero-wait slave:
  - Request seen in IDLE at cycle 0.
  - `bus_valid` high at cycle 1; slave `bus_ready`=1 at cycle 1.
  - `*_ready` at cycle 2; IDLE at cycle 3.
  - Minimum 3 cycles per transaction.
- With W wait states, ready arrives at cycle 2+W.
- Timeout: `bus_valid` high for exactly TIMEOUT cycles (cycles 1..TIMEOUT); error pulse at cycle TIMEOUT+1.
- Stall outputs are combinational from `req` and the registered ready, so the hazard unit sees the release in the same cycle as ready.
- Async reset mid-transaction drops `bus_valid` immediately, with no pulse. The slave is required to tolerate an abandoned request.

## Test plan
- **Instruction read:** `imem_req`=1, `imem_addr`=0x100, slave returns 0xDEADBEEF zero-wait → `bus_valid` cycle 1 with `bus_addr`=0x100, `bus_we`=0; `imem_ready`=1 and `imem_data`=0xDEADBEEF at cycle 2; `imem_request_stall` high cycles 0–1, low at cycle 2.
- **Simultaneous requests:** `imem_req` and `dmem_req` (write 0x12345678 to 0x200, `be`=0xF) both at cycle 0 → data granted first, `dmem_ready` at cycle 2; fetch granted from IDLE at cycle 3, `imem_ready` at cycle 5.
- **Wait states and error:** slave inserts 4 wait states then asserts `bus_error` and `bus_ready` together on a data read → `dmem_ready`=`dmem_error`=1 at cycle 6; `dmem_rdata`=0; bus outputs stable through cycles 1–5.
- **Watchdog:** TIMEOUT=8, slave never responds → `bus_valid` high cycles 1–8, `imem_ready`=`imem_error`=1 at cycle 9, then IDLE.
- **Reset and flush:** `rst_n` low during cycle 3 of a waited transaction → `bus_valid`, ready, error and data outputs 0 immediately; after release, a new request is granted normally. Separately, a request dropped at cycle 2 still produces a ready pulse on completion.

Source files
------------

// File: rtl/musb_mem_arbiter.sv
// musb_mem_arbiter
// Shares one single-beat memory bus port between the instruction-fetch and
// data-access paths of the MUSB core. Data requests always win over
// instruction requests. Bus signals stay stable until the slave responds
// or the watchdog expires. The owning master then sees a one-cycle
// ready (and optional error) pulse along with the captured read word.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/addr                   instruction read request
//   imem_data/ready/error           fetched word, completion and error pulses
//   imem_request_stall              imem_req & ~imem_ready, for the hazard unit
//   dmem_req/we/addr/wdata/be       data request
//   dmem_rdata/ready/error          read word, completion and error pulses
//   dmem_request_stall              dmem_req & ~dmem_ready, for the hazard unit
//   bus_valid/we/addr/wdata/be      registered master-side bus
//   bus_rdata/ready/error           slave response, used only while bus_valid=1
module musb_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    imem_req,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [DATA_WIDTH-1:0]   imem_data,
    output logic                    imem_ready,
    output logic                    imem_error,
    output logic                    imem_request_stall,
    input  logic                    dmem_req,
    input  logic                    dmem_we,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH/8-1:0] dmem_be,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_ready,
    output logic                    dmem_error,
    output logic                    dmem_request_stall,
    output logic                    bus_valid,
    output logic                    bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    input  logic                    bus_ready,
    input  logic                    bus_error
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    // Completion by timeout happens in the cycle the counter holds this value,
    // so bus_valid stays high for exactly TIMEOUT cycles.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        IMEM,
        DMEM,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    bus_valid_q, bus_valid_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
    logic [BE_WIDTH-1:0]     bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0]   imem_data_q, imem_data_d;
    logic                    imem_ready_q, imem_ready_d;
    logic                    imem_error_q, imem_error_d;
    logic [DATA_WIDTH-1:0]   dmem_data_q, dmem_data_d;
    logic                    dmem_ready_q, dmem_ready_d;
    logic                    dmem_error_q, dmem_error_d;

    logic                    respond;
    logic                    expired;
    logic                    done;
    logic                    fail;
    logic [DATA_WIDTH-1:0]   capture;

    // Completion decode. A slave response in the last watchdog cycle counts
    // as a normal response, and bus_error wins over bus_ready.
    always_comb begin
        respond = bus_ready | bus_error;
        expired = ~respond & (cnt_q == CNT_LAST);
        done    = respond | expired;
        fail    = bus_error | expired;
        capture = fail ? '0 : bus_rdata;
    end

    // Next-state and datapath. Ready/error default low so that they pulse
    // only during the RESP cycle that follows a completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_valid_d  = bus_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        imem_data_d  = imem_data_q;
        imem_ready_d = 1'b0;
        imem_error_d = 1'b0;
        dmem_data_d  = dmem_data_q;
        dmem_ready_d = 1'b0;
        dmem_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (dmem_req) begin
                    state_d     = DMEM;
                    bus_valid_d = 1'b1;
                    bus_we_d    = dmem_we;
                    bus_addr_d  = dmem_addr;
                    bus_wdata_d = dmem_wdata;
                    bus_be_d    = dmem_be;
                end else if (imem_req) begin
                    state_d     = IMEM;
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = imem_addr;
                    bus_wdata_d = '0;
                    bus_be_d    = '1;
                end
            end
            IMEM, DMEM: begin
                if (done) begin
                    state_d     = RESP;
                    bus_valid_d = 1'b0;
                    if (state_q == IMEM) begin
                        imem_data_d  = capture;
                        imem_ready_d = 1'b1;
                        imem_error_d = fail;
                    end else begin
                        dmem_data_d  = capture;
                        dmem_ready_d = 1'b1;
                        dmem_error_d = fail;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // Requests are ignored here: the master's req still refers to
            // the access that has just completed.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any bus access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            imem_data_q  <= '0;
            imem_ready_q <= 1'b0;
            imem_error_q <= 1'b0;
            dmem_data_q  <= '0;
            dmem_ready_q <= 1'b0;
            dmem_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            imem_data_q  <= imem_data_d;
            imem_ready_q <= imem_ready_d;
            imem_error_q <= imem_error_d;
            dmem_data_q  <= dmem_data_d;
            dmem_ready_q <= dmem_ready_d;
            dmem_error_q <= dmem_error_d;
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign imem_data  = imem_data_q;
    assign imem_ready = imem_ready_q;
    assign imem_error = imem_error_q;
    assign dmem_rdata = dmem_data_q;
    assign dmem_ready = dmem_ready_q;
    assign dmem_error = dmem_error_q;

    // Combinational so the hazard unit releases in the same cycle as ready.
    assign imem_request_stall = imem_req & ~imem_ready_q;
    assign dmem_request_stall = dmem_req & ~dmem_ready_q;

endmodule
